// File: rtl/oldland_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : oldland_mem_responder
// Oldland word-bus memory responder: on-chip RAM, wait states, range errors.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module oldland_mem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_access,
  input  logic [29:0] m_addr,
  input  logic        m_wr_en,
  input  logic [3:0]  m_bytesel,
  input  logic [31:0] m_wr_data,
  output logic [31:0] m_data,
  output logic        m_ack,
  output logic        m_error
);

  localparam int unsigned c_ADDR_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_count;
  logic [3:0]          w_count_nxt;
  logic [29:0]         r_addr;
  logic                r_wr_en;
  logic [3:0]          r_bytesel;
  logic [31:0]         r_wr_data;
  logic                r_ack;
  logic                r_error;
  logic [31:0]         r_data;
  logic [31:0]         r_mem [MEM_WORDS];

  logic                w_sample;
  logic                w_go;
  logic                w_from_live;
  logic [29:0]         w_addr;
  logic                w_wr_en;
  logic [3:0]          w_bytesel;
  logic [31:0]         w_wr_data;
  logic                w_in_range;
  logic [c_ADDR_W-1:0] w_idx;

  // RESP is the cycle in which ack/error is presented; a new request may be
  // sampled there so a streaming initiator sees acks WAIT_STATES+1 apart.
  assign w_sample = m_access && ((r_state == IDLE) || r_ack);
  assign w_go     = (WAIT_STATES == 0) ? w_sample
                  : ((r_state == WAIT) && m_access && (r_count == 4'd1));

  assign w_from_live = (r_state != WAIT);
  assign w_addr      = w_from_live ? m_addr    : r_addr;
  assign w_wr_en     = w_from_live ? m_wr_en   : r_wr_en;
  assign w_bytesel   = w_from_live ? m_bytesel : r_bytesel;
  assign w_wr_data   = w_from_live ? m_wr_data : r_wr_data;
  assign w_in_range  = ({2'b00, w_addr} < 32'(MEM_WORDS));
  assign w_idx       = w_addr[c_ADDR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      WAIT: begin
        if (!m_access) begin
          w_state_nxt = IDLE;
          w_count_nxt = 4'd0;
        end else if (r_count == 4'd1) begin
          w_state_nxt = RESP;
          w_count_nxt = 4'd0;
        end else begin
          w_count_nxt = r_count - 4'd1;
        end
      end
      default: begin
        if (w_sample) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_count_nxt = 4'(WAIT_STATES);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // RAM writes live under the reset branch so a request caught by reset never writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_ack     <= 1'b0;
      r_error   <= 1'b0;
      r_data    <= 32'd0;
      r_addr    <= 30'd0;
      r_wr_en   <= 1'b0;
      r_bytesel <= 4'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ack   <= w_go && w_in_range;
      r_error <= w_go && !w_in_range;
      if (w_sample) begin
        r_addr    <= m_addr;
        r_wr_en   <= m_wr_en;
        r_bytesel <= m_bytesel;
        r_wr_data <= m_wr_data;
      end
      if (w_go && w_in_range) begin
        if (w_wr_en) begin
          for (int b = 0; b < 4; b++) begin
            if (w_bytesel[b]) begin
              r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
          end
        end else begin
          r_data <= r_mem[w_idx];
        end
      end
    end
  end

  assign m_data  = r_data;
  assign m_ack   = r_ack;
  assign m_error = r_error;

endmodule
`default_nettype wire
